tdp_bram_be: RTL
================

# tdp_bram_be

Parametrised true-dual-port block RAM with per-byte write enables, selectable read-during-write behaviour, an optional output pipeline register and a built-in memory-clear sequencer. Each port has a read-data valid strobe, and the block detects and counts same-address collisions between the two ports. It replaces the plain 16x1024 dual-port RAM wherever buffers need byte-granular writes, deterministic collision handling or a zeroed memory after reset.

## Interface
- WIDTH, 16, data width in bits; must be a multiple of BYTE_W
- DEPTH, 1024, number of words; address width AW = $clog2(DEPTH)
- BYTE_W, 8, bits per write-enable lane; NB = WIDTH/BYTE_W
- RDW_MODE, RDW_READ_FIRST, same-port read-during-write: READ_FIRST, WRITE_FIRST or NO_CHANGE
- OUT_REG, 0, 1 adds a second output register stage (read latency 2)
- INIT_CLEAR, 1, 1 runs the clear sequence after every reset release
- CNT_W, 16, width of the collision counter
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- clear_req  in  1  one-cycle request to zero the whole memory
- busy  out  1  high while a clear is running; port requests are ignored
- en_a / en_b  in  1  port access enable
- we_a / we_b  in  NB  byte write enables (valid only with en)
- addr_a / addr_b  in  AW  word address
- din_a / din_b  in  WIDTH  write data
- dout_a / dout_b  out  WIDTH  read data
- dvalid_a / dvalid_b  out  1  dout holds the data for an accepted read
- coll  out  1  one-cycle pulse: same-address collision accepted this cycle
- coll_cnt  out  CNT_W  saturating collision count

## Operation
- Memory array is not reset. Reset clears dout_*, dvalid_*, coll and coll_cnt to 0; FSM goes to CLEAR (INIT_CLEAR=1) or READY (INIT_CLEAR=0); busy equals (state==CLEAR).
- FSM: CLEAR -> READY when clear address = DEPTH-1; READY -> CLEAR on clear_req. clear_req during CLEAR is ignored. CLEAR writes 0 to one word per cycle, ascending from 0.
- Accepted access: en_x=1 and state READY. A read happens on every accepted access where any we bit is 0 or RDW_MODE is not NO_CHANGE. Writes update only lanes with we_x[i]=1.
- Same-port read-during-write: READ_FIRST returns old word; WRITE_FIRST returns the merged new word; NO_CHANGE holds dout and dvalid stays 0 for that access.
- Cross-port, same address, one port writing: the reading port receives the old word.
- Both ports write the same address: on overlapping lanes port A wins; lanes written by only one port take that port's data.
- Collision: both accesses accepted, addr_a==addr_b, and at least one we bit set -> coll=1 for one cycle, coll_cnt+1, saturating at all-ones.

## Timing
- OUT_REG=0: dout/dvalid valid on the edge after the request (latency 1). OUT_REG=1: latency 2. dvalid is a single-cycle pulse per accepted read; dout holds its value until the next read.
- Clear: the first edge after rst_n release writes address 0; busy falls after DEPTH edges. The first port access is accepted on the cycle busy is low.
- clear_req sampled high in READY: busy=1 from the next cycle, for DEPTH cycles. Reads still in flight in the output pipeline complete normally.
- rst_n asserted mid-clear: the address counter returns to 0 and the clear restarts in full. Words already zeroed stay zeroed; memory contents are otherwise unchanged.
- coll and coll_cnt update one edge after the colliding request.

## Structure
- Package tdp_bram_pkg: rdw_mode_e {RDW_READ_FIRST, RDW_WRITE_FIRST, RDW_NO_CHANGE}, state_e {CLEAR, READY}.
- Sub-module tdp_bram_out_stage (WIDTH, OUT_REG): per-port dout/dvalid pipeline with async reset, instantiated twice.
- The array, both write processes, the clear FSM and the collision logic live in the top module. Carry (* ram_style = "block" *) on the array.

## Test plan
- Reset release, DEPTH=16 -> busy high for exactly 16 cycles; every address then reads 0x0000 with dvalid one cycle later (two with OUT_REG=1).
- Port A writes 0xABCD to address 5 with we=2'b01, after 0x1234 was written -> reading address 5 returns 0x12CD.
- RDW_MODE: address 3 holds 0x1111; same-port write 0x2222 with read -> READ_FIRST 0x1111, WRITE_FIRST 0x2222, NO_CHANGE holds dout with no dvalid.
- Both ports write address 7: A 0xAAAA we=01, B 0xBBBB we=11 -> word 0xBBAA; coll pulses once; coll_cnt=1. With CNT_W=2, 5 collisions -> coll_cnt=3.
- clear_req after addresses 0..15 are filled, with rst_n pulsed low at clear address 8 -> the clear restarts from 0; after busy falls all words read 0; port requests during busy cause no writes and no dvalid.

Source files
------------

// File: rtl/tdp_bram_pkg.sv
// tdp_bram_pkg: shared types for the byte-enable true-dual-port RAM.
//   rdw_mode_e : same-port read-during-write behaviour
//   state_e    : clear sequencer state
package tdp_bram_pkg;

    typedef enum logic [1:0] {
        RDW_READ_FIRST,
        RDW_WRITE_FIRST,
        RDW_NO_CHANGE
    } rdw_mode_e;

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

endpackage

// File: rtl/tdp_bram_out_stage.sv
// tdp_bram_out_stage: per-port read-data pipeline (one or two register stages).
//   clk, rst_n : clock, async active-low reset
//   i_rd       : an accepted read happened this cycle
//   i_rdata    : word to return for that read
//   o_dout     : read data, held until the next read arrives
//   o_dvalid   : one-cycle strobe when o_dout carries fresh read data
module tdp_bram_out_stage #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned OUT_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_rd,
    input  logic [WIDTH-1:0] i_rdata,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dvalid
);

    logic [WIDTH-1:0] r_d1;
    logic             r_v1;

    // First stage: capture only on a read so the data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= i_rd;
            if (i_rd) begin
                r_d1 <= i_rdata;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] r_d2;
            logic             r_v2;

            // Optional second stage, same hold behaviour as the first.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d2 <= '0;
                    r_v2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                    end
                end
            end

            assign o_dout   = r_d2;
            assign o_dvalid = r_v2;
        end else begin : g_no_out_reg
            assign o_dout   = r_d1;
            assign o_dvalid = r_v1;
        end
    endgenerate

endmodule

// File: rtl/tdp_bram_be.sv
// tdp_bram_be: true-dual-port block RAM with byte write enables, selectable
// read-during-write mode, optional output register, clear sequencer and
// same-address collision detection.
//   clk, rst_n            : clock, async active-low reset
//   clear_req             : one-cycle request to zero the memory
//   busy                  : clear running, port requests ignored
//   en_x/we_x/addr_x/din_x: port access (x = a, b)
//   dout_x/dvalid_x       : read data and its valid strobe
//   coll/coll_cnt         : collision pulse and saturating collision count
module tdp_bram_be
    import tdp_bram_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned BYTE_W     = 8,
    parameter rdw_mode_e   RDW_MODE   = RDW_READ_FIRST,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned INIT_CLEAR = 1,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned NB        = WIDTH / BYTE_W,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_req,
    output logic             busy,
    input  logic             en_a,
    input  logic [NB-1:0]    we_a,
    input  logic [AW-1:0]    addr_a,
    input  logic [WIDTH-1:0] din_a,
    output logic [WIDTH-1:0] dout_a,
    output logic             dvalid_a,
    input  logic             en_b,
    input  logic [NB-1:0]    we_b,
    input  logic [AW-1:0]    addr_b,
    input  logic [WIDTH-1:0] din_b,
    output logic [WIDTH-1:0] dout_b,
    output logic             dvalid_b,
    output logic             coll,
    output logic [CNT_W-1:0] coll_cnt
);

    (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [DEPTH];

    state_e           r_state;
    logic [AW-1:0]    r_clr_addr;
    logic             r_coll;
    logic [CNT_W-1:0] r_coll_cnt;

    logic             w_acc_a;
    logic             w_acc_b;
    logic             w_rd_a;
    logic             w_rd_b;
    logic             w_coll;
    logic [WIDTH-1:0] w_old_a;
    logic [WIDTH-1:0] w_old_b;
    logic [WIDTH-1:0] w_new_a;
    logic [WIDTH-1:0] w_new_b;
    logic [WIDTH-1:0] w_rdata_a;
    logic [WIDTH-1:0] w_rdata_b;

    // rst_n gates the array so clock edges seen during reset never touch memory.
    assign w_acc_a = rst_n && en_a && (r_state == READY);
    assign w_acc_b = rst_n && en_b && (r_state == READY);

    // NO_CHANGE suppresses the read only when the access writes every lane.
    assign w_rd_a = w_acc_a && (!(&we_a) || (RDW_MODE != RDW_NO_CHANGE));
    assign w_rd_b = w_acc_b && (!(&we_b) || (RDW_MODE != RDW_NO_CHANGE));

    assign w_old_a = r_mem[addr_a];
    assign w_old_b = r_mem[addr_b];

    // Each port's own write merged onto the old word (WRITE_FIRST read data).
    always_comb begin
        w_new_a = w_old_a;
        w_new_b = w_old_b;
        for (int unsigned i = 0; i < NB; i++) begin
            if (we_a[i]) begin
                w_new_a[i*BYTE_W +: BYTE_W] = din_a[i*BYTE_W +: BYTE_W];
            end
            if (we_b[i]) begin
                w_new_b[i*BYTE_W +: BYTE_W] = din_b[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // The other port's write is never visible here: cross-port reads see the old word.
    assign w_rdata_a = (RDW_MODE == RDW_WRITE_FIRST) ? w_new_a : w_old_a;
    assign w_rdata_b = (RDW_MODE == RDW_WRITE_FIRST) ? w_new_b : w_old_b;

    // Array writes. Port A lanes are assigned after port B so A wins on overlap.
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == CLEAR)) begin
            r_mem[r_clr_addr] <= '0;
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (w_acc_b && we_b[i]) begin
                    r_mem[addr_b][i*BYTE_W +: BYTE_W] <= din_b[i*BYTE_W +: BYTE_W];
                end
            end
            for (int unsigned i = 0; i < NB; i++) begin
                if (w_acc_a && we_a[i]) begin
                    r_mem[addr_a][i*BYTE_W +: BYTE_W] <= din_a[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Clear sequencer: one word per cycle from 0 up to DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (INIT_CLEAR != 0) begin
                r_state <= CLEAR;
            end else begin
                r_state <= READY;
            end
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_clr_addr == AW'(DEPTH - 1)) begin
                        r_state    <= READY;
                        r_clr_addr <= '0;
                    end else begin
                        r_clr_addr <= r_clr_addr + AW'(1);
                    end
                end
                READY: begin
                    if (clear_req) begin
                        r_state    <= CLEAR;
                        r_clr_addr <= '0;
                    end
                end
                default: begin
                    r_state <= READY;
                end
            endcase
        end
    end

    assign busy = (r_state == CLEAR);

    assign w_coll = w_acc_a && w_acc_b && (addr_a == addr_b) && ((|we_a) || (|we_b));

    // Collision pulse and saturating count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coll     <= 1'b0;
            r_coll_cnt <= '0;
        end else begin
            r_coll <= w_coll;
            if (w_coll && !(&r_coll_cnt)) begin
                r_coll_cnt <= r_coll_cnt + CNT_W'(1);
            end
        end
    end

    assign coll     = r_coll;
    assign coll_cnt = r_coll_cnt;

    tdp_bram_out_stage #(
        .WIDTH   (WIDTH),
        .OUT_REG (OUT_REG)
    ) u_out_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_rd     (w_rd_a),
        .i_rdata  (w_rdata_a),
        .o_dout   (dout_a),
        .o_dvalid (dvalid_a)
    );

    tdp_bram_out_stage #(
        .WIDTH   (WIDTH),
        .OUT_REG (OUT_REG)
    ) u_out_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_rd     (w_rd_b),
        .i_rdata  (w_rdata_b),
        .o_dout   (dout_b),
        .o_dvalid (dvalid_b)
    );

endmodule
